// File: rtl/maze_pkg.sv
// Shared constants and helpers for the maze room renderer: default 640x480@60 timing,
// wall-mask bit positions, legacy tile-code translation and the wall band equation.
package maze_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int MASK_N = 3;
    localparam int MASK_E = 2;
    localparam int MASK_S = 1;
    localparam int MASK_W = 0;

    typedef logic [3:0] mask_t;

    typedef enum logic [3:0] {
        TILE_VCORR     = 4'd0,
        TILE_HCORR     = 4'd1,
        TILE_CROSS     = 4'd6,
        TILE_CLOSED_UP = 4'd7,
        TILE_T_UP      = 4'd11
    } tile_e;

    // Codes the old drawer never defined map to a fully closed room.
    function automatic mask_t tile_to_mask(input tile_e tile);
        case (tile)
            TILE_VCORR:     return 4'b0101;
            TILE_HCORR:     return 4'b1010;
            TILE_CROSS:     return 4'b0000;
            TILE_CLOSED_UP: return 4'b1101;
            TILE_T_UP:      return 4'b1000;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic wall_eq(input mask_t m, input logic l, input logic r,
                                     input logic t, input logic b);
        return ((l | r) & (t | b)) | (m[MASK_N] & t) | (m[MASK_S] & b)
             | (m[MASK_W] & l) | (m[MASK_E] & r);
    endfunction

endpackage

// File: rtl/maze_room_renderer_if.sv
// Game-side bus of the renderer: room select, map writes, collision queries and video outputs.
interface maze_room_renderer_if #(
    parameter int MAP_W = 8,
    parameter int MAP_H = 8,
    parameter int XW    = 10
);
    localparam int MXW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int MYW = (MAP_H > 1) ? $clog2(MAP_H) : 1;

    logic [MXW-1:0] room_x;
    logic [MYW-1:0] room_y;
    logic           map_wr_en;
    logic [MXW-1:0] map_wr_x;
    logic [MYW-1:0] map_wr_y;
    logic [3:0]     map_wr_mask;
    logic           map_wr_ready;
    logic           q_valid;
    logic [XW-1:0]  q_x;
    logic [XW-1:0]  q_y;
    logic [XW-1:0]  q_size;
    logic           q_ready;
    logic           r_valid;
    logic           r_hit;
    logic [XW-1:0]  pix_x;
    logic [XW-1:0]  pix_y;
    logic           hsync;
    logic           vsync;
    logic           blank_n;
    logic           wall_pix;
    logic           frame_start;
    logic           pix_en;

    modport master (
        output room_x, room_y, map_wr_en, map_wr_x, map_wr_y, map_wr_mask,
               q_valid, q_x, q_y, q_size,
        input  map_wr_ready, q_ready, r_valid, r_hit, pix_x, pix_y,
               hsync, vsync, blank_n, wall_pix, frame_start, pix_en
    );

    modport slave (
        input  room_x, room_y, map_wr_en, map_wr_x, map_wr_y, map_wr_mask,
               q_valid, q_x, q_y, q_size,
        output map_wr_ready, q_ready, r_valid, r_hit, pix_x, pix_y,
               hsync, vsync, blank_n, wall_pix, frame_start, pix_en
    );

endinterface

// File: rtl/vga_timing.sv
// Generic VGA timing: pixel-rate divider, h/v counters and registered sync/blank/coordinate outputs.
module vga_timing import maze_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int PIX_DIV  = 2,
    parameter int XW       = 10,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HCW     = $clog2(H_TOTAL),
    localparam int VCW     = $clog2(V_TOTAL)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    output logic           o_pix_en,
    output logic [HCW-1:0] o_h,
    output logic [VCW-1:0] o_v,
    output logic           o_frame_tick,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_blank_n,
    output logic           o_frame_start,
    output logic [XW-1:0]  o_pix_x,
    output logic [XW-1:0]  o_pix_y
);
    localparam int   DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic L_SP  = (SYNC_POL != 0);
    localparam int   HS_LO = H_ACTIVE + H_FP;
    localparam int   VS_LO = V_ACTIVE + V_FP;

    logic [DW-1:0]  r_div;
    logic           r_pix_en;
    logic [HCW-1:0] r_h;
    logic [VCW-1:0] r_v;
    logic [31:0]    w_h32, w_v32;
    logic           w_h_last, w_v_last, w_hs_on, w_vs_on, w_active;

    assign w_h32    = 32'(r_h);
    assign w_v32    = 32'(r_v);
    assign w_h_last = (w_h32 == H_TOTAL - 1);
    assign w_v_last = (w_v32 == V_TOTAL - 1);
    assign w_hs_on  = (w_h32 >= HS_LO) && (w_h32 < HS_LO + H_SYNC);
    assign w_vs_on  = (w_v32 >= VS_LO) && (w_v32 < VS_LO + V_SYNC);
    assign w_active = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);

    assign o_pix_en     = r_pix_en;
    assign o_h          = r_h;
    assign o_v          = r_v;
    assign o_frame_tick = r_pix_en && (r_h == '0) && (r_v == '0);

    // pix_en is registered so it is low in reset; it is high while r_div sits at 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= (r_div == DW'(PIX_DIV - 1));
            if (r_div == DW'(PIX_DIV - 1)) r_div <= '0;
            else                           r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_pix_en) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + VCW'(1);
            end else begin
                r_h <= r_h + HCW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hsync       <= ~L_SP;
            o_vsync       <= ~L_SP;
            o_blank_n     <= 1'b0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= o_frame_tick;
            if (r_pix_en) begin
                o_hsync   <= w_hs_on ? L_SP : ~L_SP;
                o_vsync   <= w_vs_on ? L_SP : ~L_SP;
                o_blank_n <= w_active;
                o_pix_x   <= w_h32[XW-1:0];
                o_pix_y   <= w_v32[XW-1:0];
            end
        end
    end

endmodule

// File: rtl/maze_room_renderer.sv
// Maze room renderer: VGA timing, writable per-room wall-mask map latched at frame start,
// per-pixel wall output and a registered box-collision query port.
module maze_room_renderer import maze_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int PIX_DIV  = 2,
    parameter int WALL     = 100,
    parameter int MAP_W    = 8,
    parameter int MAP_H    = 8,
    parameter int XW       = 10
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    maze_room_renderer_if.slave bus
);
    localparam int HCW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VCW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic           w_pix_en, w_frame_tick;
    logic [HCW-1:0] w_h;
    logic [VCW-1:0] w_v;
    logic           w_hsync, w_vsync, w_blank_n, w_frame_start;
    logic [XW-1:0]  w_pix_x, w_pix_y;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .PIX_DIV(PIX_DIV), .XW(XW)
    ) u_timing (
        .i_clk(CLOCK_50), .i_rst(reset),
        .o_pix_en(w_pix_en), .o_h(w_h), .o_v(w_v), .o_frame_tick(w_frame_tick),
        .o_hsync(w_hsync), .o_vsync(w_vsync), .o_blank_n(w_blank_n),
        .o_frame_start(w_frame_start), .o_pix_x(w_pix_x), .o_pix_y(w_pix_y)
    );

    mask_t       r_map [MAP_H][MAP_W];
    mask_t       r_room_mask;
    mask_t       w_latch_mask, w_frame_mask;
    logic        w_map_ready, r_wall_pix;
    logic [31:0] w_h32, w_v32;
    logic        w_active, w_l, w_r, w_t, w_b;

    assign w_h32        = 32'(w_h);
    assign w_v32        = 32'(w_v);
    assign w_map_ready  = (w_v32 >= V_ACTIVE);
    assign w_latch_mask = r_map[bus.room_y][bus.room_x];
    // The first pixel of a frame must already use the mask being latched on the same edge.
    assign w_frame_mask = w_frame_tick ? w_latch_mask : r_room_mask;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int y = 0; y < MAP_H; y++)
                for (int x = 0; x < MAP_W; x++)
                    r_map[y][x] <= 4'hF;
            r_room_mask <= 4'hF;
        end else begin
            if (w_frame_tick) r_room_mask <= w_latch_mask;
            if (bus.map_wr_en && w_map_ready)
                r_map[bus.map_wr_y][bus.map_wr_x] <= bus.map_wr_mask;
        end
    end

    assign w_active = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
    assign w_l      = (w_h32 < WALL);
    assign w_r      = (w_h32 >= H_ACTIVE - WALL);
    assign w_t      = (w_v32 < WALL);
    assign w_b      = (w_v32 >= V_ACTIVE - WALL);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)         r_wall_pix <= 1'b0;
        else if (w_pix_en) r_wall_pix <= w_active && wall_eq(w_frame_mask, w_l, w_r, w_t, w_b);
    end

    logic [XW:0] w_qx_end, w_qy_end;
    logic        w_ql, w_qr, w_qt, w_qb, w_qover, w_qhit, w_qacc;
    logic        r_q_ready, r_rsp_valid, r_rsp_hit;

    assign w_qx_end = {1'b0, bus.q_x} + {1'b0, bus.q_size};
    assign w_qy_end = {1'b0, bus.q_y} + {1'b0, bus.q_size};
    assign w_ql     = (32'(bus.q_x) < WALL);
    assign w_qr     = (32'(w_qx_end) > H_ACTIVE - WALL);
    assign w_qt     = (32'(bus.q_y) < WALL);
    assign w_qb     = (32'(w_qy_end) > V_ACTIVE - WALL);
    assign w_qover  = (32'(w_qx_end) > H_ACTIVE) || (32'(w_qy_end) > V_ACTIVE);
    assign w_qhit   = w_qover || wall_eq(r_room_mask, w_ql, w_qr, w_qt, w_qb);
    assign w_qacc   = bus.q_valid && r_q_ready;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_q_ready   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
        end else begin
            r_q_ready   <= 1'b1;
            r_rsp_valid <= w_qacc;
            if (w_qacc) r_rsp_hit <= w_qhit;
        end
    end

    assign bus.map_wr_ready = w_map_ready;
    assign bus.q_ready      = r_q_ready;
    assign bus.r_valid      = r_rsp_valid;
    assign bus.r_hit        = r_rsp_hit;
    assign bus.pix_x        = w_pix_x;
    assign bus.pix_y        = w_pix_y;
    assign bus.hsync        = w_hsync;
    assign bus.vsync        = w_vsync;
    assign bus.blank_n      = w_blank_n;
    assign bus.wall_pix     = r_wall_pix;
    assign bus.frame_start  = w_frame_start;
    assign bus.pix_en       = w_pix_en;

endmodule

// File: tb/tb_maze_room_renderer.sv
// Bench for maze_room_renderer on a shrunken video mode: a pixel-index reference model
// checks every output each clock, plus directed wall/query points and a mid-frame reset.
module tb_maze_room_renderer;
    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 4;
    localparam int SP = 0, PD = 2, WL = 10, MW = 8, MH = 8, XW = 10;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME_CLK = HT * VT * PD;
    localparam logic SPL = (SP != 0);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maze_room_renderer_if #(.MAP_W(MW), .MAP_H(MH), .XW(XW)) bus ();

    maze_room_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(SP), .PIX_DIV(PD), .WALL(WL), .MAP_W(MW), .MAP_H(MH), .XW(XW)
    ) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

    int n_pass = 0, n_total = 0;

    // reference model state: n = pixels already emitted since reset
    int         n, phase, presync, last_h, last_v;
    logic       pen_prev, synced, exp_qr;
    logic [3:0] mmap [MH][MW];
    logic [3:0] mmask;
    logic       exp_hs, exp_vs, exp_bn, exp_wall, exp_fs, exp_rv, exp_rh;
    int         exp_px, exp_py;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic wall_of(input logic [3:0] m, input logic l, input logic r,
                                     input logic t, input logic b);
        logic corner;
        corner = (l || r) && (t || b);
        return corner || (m[3] && t) || (m[1] && b) || (m[0] && l) || (m[2] && r);
    endfunction

    function automatic logic box_hit(input int x, input int y, input int s, input logic [3:0] m);
        if (x + s > HA || y + s > VA) return 1'b1;
        return wall_of(m, x < WL, x + s > HA - WL, y < WL, y + s > VA - WL);
    endfunction

    task automatic model_reset();
        n = 0; phase = 0; presync = 0; last_h = -1; last_v = -1;
        pen_prev = 1'b0; synced = 1'b0; exp_qr = 1'b0;
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++)
                mmap[y][x] = 4'hF;
        mmask = 4'hF;
        exp_hs = !SPL; exp_vs = !SPL; exp_bn = 1'b0; exp_wall = 1'b0;
        exp_fs = 1'b0; exp_rv = 1'b0; exp_rh = 1'b0; exp_px = 0; exp_py = 0;
    endtask

    task automatic chk_reset();
        chk("rst_pix_en", bus.pix_en, 0);
        chk("rst_hsync", bus.hsync, !SPL);
        chk("rst_vsync", bus.vsync, !SPL);
        chk("rst_blank_n", bus.blank_n, 0);
        chk("rst_wall_pix", bus.wall_pix, 0);
        chk("rst_pix_x", bus.pix_x, 0);
        chk("rst_pix_y", bus.pix_y, 0);
        chk("rst_frame_start", bus.frame_start, 0);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_r_hit", bus.r_hit, 0);
        chk("rst_q_ready", bus.q_ready, 0);
        chk("rst_map_wr_ready", bus.map_wr_ready, 0);
    endtask

    // One clock: account for the edge just taken, then compare every output.
    task automatic cyc();
        int h, v, vcur;
        logic acc;
        @(negedge clk);
        vcur   = (n / HT) % VT;
        acc    = bus.q_valid && exp_qr;
        exp_qr = 1'b1;
        exp_rv = acc;
        if (acc) exp_rh = box_hit(int'(bus.q_x), int'(bus.q_y), int'(bus.q_size), mmask);
        exp_fs = 1'b0;
        if (pen_prev) begin
            h = n % HT;
            v = (n / HT) % VT;
            if (h == 0 && v == 0) mmask = mmap[bus.room_y][bus.room_x];
            exp_bn   = (h < HA) && (v < VA);
            exp_hs   = (h >= HA + HFP && h < HA + HFP + HS) ? SPL : !SPL;
            exp_vs   = (v >= VA + VFP && v < VA + VFP + VS) ? SPL : !SPL;
            exp_wall = exp_bn && wall_of(mmask, h < WL, h >= HA - WL, v < WL, v >= VA - WL);
            exp_px   = h;
            exp_py   = v;
            exp_fs   = (h == 0 && v == 0);
            last_h   = h;
            last_v   = v;
            n++;
        end
        if (bus.map_wr_en && vcur >= VA) mmap[bus.map_wr_y][bus.map_wr_x] = bus.map_wr_mask;

        if (synced) begin
            chk("pix_en", bus.pix_en, (phase % PD) == 0);
            phase++;
        end else if (bus.pix_en === 1'b1) begin
            synced = 1'b1;
            phase  = 1;
        end else begin
            presync++;
            if (presync > PD + 1) chk("pix_en_start", bus.pix_en, 1);
        end
        pen_prev = bus.pix_en;

        chk("hsync", bus.hsync, exp_hs);
        chk("vsync", bus.vsync, exp_vs);
        chk("blank_n", bus.blank_n, exp_bn);
        chk("wall_pix", bus.wall_pix, exp_wall);
        chk("frame_start", bus.frame_start, exp_fs);
        if (exp_bn) begin
            chk("pix_x", bus.pix_x, exp_px);
            chk("pix_y", bus.pix_y, exp_py);
        end
        chk("map_wr_ready", bus.map_wr_ready, ((n / HT) % VT) >= VA);
        chk("q_ready", bus.q_ready, exp_qr);
        chk("r_valid", bus.r_valid, exp_rv);
        if (exp_rv) chk("r_hit", bus.r_hit, exp_rh);
    endtask

    task automatic run_to(input int h, input int v);
        int k;
        k = 0;
        while (!(last_h == h && last_v == v) && k < 2 * FRAME_CLK + 20) begin
            cyc();
            k++;
        end
        if (!(last_h == h && last_v == v)) begin
            n_total++;
            $error("FAIL run_to timeout observed=(%0d,%0d) expected=(%0d,%0d)", last_h, last_v, h, v);
        end
    endtask

    task automatic qry(input int x, input int y, input int s, input logic exp_hit, input string tag);
        bus.q_valid = 1'b1;
        bus.q_x     = XW'(x);
        bus.q_y     = XW'(y);
        bus.q_size  = XW'(s);
        cyc();
        chk({tag, "_valid"}, bus.r_valid, 1);
        chk({tag, "_hit"}, bus.r_hit, exp_hit);
    endtask

    task automatic wr(input int x, input int y, input logic [3:0] m);
        bus.map_wr_en   = 1'b1;
        bus.map_wr_x    = 3'(x);
        bus.map_wr_y    = 3'(y);
        bus.map_wr_mask = m;
        cyc();
        bus.map_wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.room_x = '0; bus.room_y = '0;
        bus.map_wr_en = 1'b0; bus.map_wr_x = '0; bus.map_wr_y = '0; bus.map_wr_mask = '0;
        bus.q_valid = 1'b0; bus.q_x = '0; bus.q_y = '0; bus.q_size = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;

        // all rooms closed: wall band edges of room (0,0)
        run_to(9, 20);  chk("px_9_20", bus.wall_pix, 1);
        run_to(10, 20); chk("px_10_20", bus.wall_pix, 0);
        run_to(32, 29); chk("px_32_29", bus.wall_pix, 0);
        run_to(32, 30); chk("px_32_30", bus.wall_pix, 1);

        // write while in the active area is dropped
        wr(5, 5, 4'h0);
        chk("wr_ready_active", bus.map_wr_ready, 0);

        run_to(0, VA);
        chk("wr_ready_vblank", bus.map_wr_ready, 1);
        wr(3, 2, 4'b0101);
        wr(1, 1, 4'b0000);
        bus.room_x = 3'd3; bus.room_y = 3'd2;
        run_to(32, 5); chk("ew_32_5", bus.wall_pix, 0);
        run_to(5, 20); chk("ew_5_20", bus.wall_pix, 1);

        // crossroad room for the collision queries
        bus.room_x = 3'd1; bus.room_y = 3'd1;
        run_to(0, 0);
        chk("frame_start_f2", bus.frame_start, 1);
        qry(10, 20, 4, 1'b0, "q_open");
        qry(6, 20, 4, 1'b0, "q_left_band");
        qry(7, 7, 4, 1'b1, "q_corner");
        qry(62, 20, 4, 1'b1, "q_past_edge");
        qry(5, 20, 0, 1'b0, "q_point_open");
        qry(5, 5, 0, 1'b1, "q_point_corner");
        bus.q_valid = 1'b0;
        cyc();
        chk("q_idle", bus.r_valid, 0);

        // randomized traffic over about one and a half frames
        bus.room_x = 3'd5; bus.room_y = 3'd5;
        for (int i = 0; i < FRAME_CLK + FRAME_CLK / 2; i++) begin
            bus.q_valid     = 1'($urandom_range(0, 1));
            bus.q_x         = XW'($urandom_range(0, 70));
            bus.q_y         = XW'($urandom_range(0, 45));
            bus.q_size      = XW'($urandom_range(0, 12));
            bus.map_wr_en   = ($urandom_range(0, 7) == 0);
            bus.map_wr_x    = 3'($urandom_range(0, MW - 1));
            bus.map_wr_y    = 3'($urandom_range(0, MH - 1));
            bus.map_wr_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 999) == 0) begin
                bus.room_x = 3'($urandom_range(0, MW - 1));
                bus.room_y = 3'($urandom_range(0, MH - 1));
            end
            cyc();
        end
        bus.q_valid = 1'b0; bus.map_wr_en = 1'b0;

        // room change mid-frame must wait for the next frame
        run_to(0, 0);
        run_to(0, 20);
        bus.room_x = bus.room_x + 3'd1;
        run_to(0, 0);
        chk("frame_start_f_change", bus.frame_start, 1);

        // asynchronous reset in the middle of a frame
        run_to(0, 30);
        #1 rst = 1'b1;
        #1 chk_reset();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_to(0, 0);
        chk("frame_start_after_rst", bus.frame_start, 1);
        run_to(9, 20); chk("rst_px_9_20", bus.wall_pix, 1);
        run_to(0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/maze_room_renderer.md
Name: maze_room_renderer

Overview:
- Parametrised successor to the fixed-640x480 maze room drawer: generic VGA timing generator, writable MAP_W x MAP_H room map holding per-room wall masks, and a per-pixel wall renderer.
- Adds a registered box-collision query port for the player logic.
- Sits between the game top level and the VGA DAC pins. The top level muxes colours from wall_pix and the player sprite.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- PIX_DIV, 2, CLOCK_50 cycles per pixel (>=1)
- WALL, 100, wall thickness in pixels
- MAP_W, 8, rooms per map row
- MAP_H, 8, map rows
- XW, 10, pixel-coordinate width

Ports:
- CLOCK_50 in 1 system clock
- reset in 1 async, active-high
- room_x in clog2(MAP_W) current room column
- room_y in clog2(MAP_H) current room row
- map_wr_en in 1 map write request
- map_wr_x in clog2(MAP_W) write column
- map_wr_y in clog2(MAP_H) write row
- map_wr_mask in 4 wall mask {N,E,S,W}, 1 = closed
- map_wr_ready out 1 write accepted when high (vertical blank only)
- q_valid in 1 collision query strobe
- q_x, q_y in XW box top-left, active-area coords
- q_size in XW box side length
- q_ready out 1 query accept
- r_valid out 1 response pulse
- r_hit out 1 collision result
- pix_x, pix_y out XW active-area coordinate of current pixel
- hsync, vsync out 1 sync outputs
- blank_n out 1 high in active area
- wall_pix out 1 current pixel is wall
- frame_start out 1 one-clock pulse at first pixel of frame
- pix_en out 1 pixel-rate enable (VGA_CLK source)

Behaviour:
- Reset values: counters 0, pix_en 0, hsync/vsync inactive (!SYNC_POL), blank_n 0, wall_pix 0, pix_x/pix_y 0, frame_start 0, r_valid 0, r_hit 0, q_ready 0.
- Every map cell resets to 4'hF; room_mask resets to 4'hF.
- Divider: counts 0..PIX_DIV-1 and asserts pix_en for one clock when the count is 0. With PIX_DIV=1, pix_en is held high.
- On pix_en, h counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. On wrap, v advances and wraps at V_TOTAL.
- Active area is h<H_ACTIVE and v<V_ACTIVE. Sync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for v.
- All video outputs are registered with a latency of 1 pix_en from the counter state. They are mutually aligned and change only on a pix_en cycle.
- Room latch: on the pix_en cycle where h==0 and v==0, room_mask <= map[room_y][room_x] and frame_start pulses. Room changes therefore take effect only at frame boundaries (no tearing).
- Wall equation over the active area, with L=x<WALL, R=x>=H_ACTIVE-WALL, T=y<WALL, B=y>=V_ACTIVE-WALL:
  - wall = (L|R)&(T|B) | N&T | S&B | W&L | E&R
  - wall_pix = 0 outside the active area.
- Map write: map_wr_ready = (v >= V_ACTIVE). A write commits on a clock with map_wr_en && map_wr_ready; a request while not ready is dropped.
- Write coinciding with a room latch of the same cell: the latch takes the old value (read-before-write).
- Collision: q_ready = 1 out of reset. A query accepted on a clock with q_valid produces r_valid=1 for exactly one clock on the next clock, with r_hit evaluated against the current room_mask.
- Collision bands: L=q_x<WALL, R=q_x+q_size>H_ACTIVE-WALL, T=q_y<WALL, B=q_y+q_size>V_ACTIVE-WALL, using the same equation as the wall render.
- Sums are computed at XW+1 bits. Any box extending past H_ACTIVE or V_ACTIVE forces hit. q_size=0 gives hit=0 unless the point lies in a wall.
- Back-to-back queries are allowed, one per clock.
- Reset mid-frame: immediate return to reset values. The map is reinitialised and the next frame starts at h=v=0.

Decomposition:
- Package maze_pkg holds:
  - default timing constants for 640x480@60
  - mask bit indices N=3, E=2, S=1, W=0
  - legacy tile-code to mask table: 0 vertical corridor = E|W, 1 horizontal = N|S, 7 closed-up = N|E|W, …, 11 T-up = N, 6 crossroad = 0
- Sub-module vga_timing: divider, counters, sync, active, frame_start. The renderer, map and collision logic stay in the top module.

Test Plan:
- Reset release, default params: first hsync low at h=656 for 96 pixels; line length 800 pix_en; vsync low at v=490–491; frame length 420000 pix_en = 840000 clocks.
- Map reset (all 4'hF), room (0,0): pixel (99,240) wall=1, (100,240) wall=0, (320,379) wall=0, (320,380) wall=1.
- During vblank write mask 4'b0101 (E|W) to (3,2), select room (3,2): next frame pixel (320,50) wall=0, (50,240) wall=1; a write attempted at v=100 is dropped with map_wr_ready=0.
- Mask 0 (crossroad): query (q_x=100, q_y=200, q_size=16) -> r_hit=0 one clock later; (84,200,16) -> 0; (90,90,16) -> 1 (corner).
- Box beyond edge: (630,200,16) -> r_hit=1. Back-to-back queries on consecutive clocks yield consecutive r_valid pulses with correct results.
- room_x changes mid-frame at v=200: wall_pix is unchanged until frame_start. Assert reset at v=300: all outputs return to reset values within one clock.
